uart_rx: RTL and testbench

- Asynchronous serial receiver, the receive-side counterpart of the team's uart_tx.
- Frame format: 8N1, LSB first.
- Oversamples the line at CLKS_PER_BIT clocks per bit, resolves each bit at mid-bit, and presents the assembled word on a valid/read handshake.
- Flags framing errors and overruns; sits between the board RX pin and the consumer logic.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_rx and uart_tx.
// Contents:
//   state_t   - receiver FSM state encoding (IDLE, START, DATA, STOP, BREAK)
//   IDLE_BIT  - line level while no frame is being sent
//   START_BIT - line level of the start bit
//   END_BIT   - line level of the stop bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic IDLE_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT   = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single asynchronous bit.
// Parameters:
//   RESET_VAL - value both flops take on reset (choose the idle level of the input)
// Ports:
//   clk - destination clock
//   rst - synchronous, active-high reset
//   d   - asynchronous input
//   q   - synchronized output, two clk cycles behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage shift register: the first stage may go metastable, the second gives it a cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style asynchronous serial receiver, LSB first, oversampled at
// CLKS_PER_BIT clocks per bit and resolved at mid-bit.
// Parameters:
//   WIDTH        - data bits per frame
//   CLKS_PER_BIT - i_clk cycles per bit period (4 or more)
// Ports:
//   i_clk       - system clock, rising edge
//   i_rst       - synchronous, active-high reset
//   i_uart_rx   - serial line, asynchronous, idles high
//   i_rd        - consumer takes o_data this cycle (ignored while o_valid=0)
//   o_data      - last received word, LSB = first data bit
//   o_valid     - o_data holds an unread word
//   o_busy      - a frame is in progress
//   o_frame_err - one-cycle pulse: stop bit sampled low
//   o_overrun   - one-cycle pulse: frame completed while an unread word was held
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_uart_rx,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_frame_err,
  output logic             o_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic             rx_s;
  state_t           state;
  logic [CW-1:0]    clk_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;

  sync_2ff #(.RESET_VAL(IDLE_BIT)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_uart_rx),
    .q   (rx_s)
  );

  // Receive FSM with its counters, shift register, handshake and status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;

      // A word loaded later in this block overrides this clear.
      if (i_rd && o_valid) begin
        o_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (rx_s == START_BIT) begin
            state  <= START;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (rx_s == START_BIT) begin
              state <= DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as line noise.
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (rx_s == END_BIT) begin
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              state  <= IDLE;
              o_busy <= 1'b0;
              if (!o_valid || i_rd) begin
                o_data  <= shift;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        BREAK: begin
          // A line held low must go high before a new start edge can count.
          if (rx_s == IDLE_BIT) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          bit_cnt <= '0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (WIDTH=8, CLKS_PER_BIT=4).
// Frames are bit-banged on negative clock edges; expected words are queued
// when a frame is sent and compared when o_valid rises.
module tb_uart_rx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             line = 1'b1;
  logic             man_rd = 1'b0;
  logic             auto_rd = 1'b0;
  logic             rd;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;
  logic             fe;
  logic             ov;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rx_cnt = 0;
  int f0, o0, r0;
  logic valid_d = 1'b0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] exp_w;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] b55;

  always #5 clk = ~clk;

  // Loopback mode reads every word the cycle it appears.
  assign rd = man_rd | (auto_rd & valid);

  uart_rx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_uart_rx   (line),
    .i_rd        (rd),
    .o_data      (data),
    .o_valid     (valid),
    .o_busy      (busy),
    .o_frame_err (fe),
    .o_overrun   (ov)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one frame starting at the current negedge; returns CPB*(WIDTH+2) negedges later.
  task automatic send(input logic [WIDTH-1:0] b, input logic stop);
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < WIDTH; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    line = stop;
    repeat (CPB) @(negedge clk);
  endtask

  // Called right after send(): word must be present now, then read it out.
  task automatic recv_read(input string tag);
    @(negedge clk);
    check(tag, {31'd0, valid}, 32'd1);
    man_rd = 1'b1;
    @(negedge clk);
    man_rd = 1'b0;
    check({tag, "_cleared"}, {31'd0, valid}, 32'd0);
  endtask

  // Monitor: count status pulses and score each newly presented word.
  initial forever begin
    @(negedge clk);
    if (fe === 1'b1) fe_cnt++;
    if (ov === 1'b1) ov_cnt++;
    if (valid === 1'b1 && valid_d !== 1'b1) begin
      rx_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_word", {24'd0, data}, 32'hFFFF_FFFF);
      end else begin
        exp_w = sb.pop_front();
        check("rx_word", {24'd0, data}, {24'd0, exp_w});
      end
    end
    valid_d = valid;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_err", {31'd0, fe}, 32'd0);
    check("rst_overrun", {31'd0, ov}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame: o_valid exactly 41 cycles after the start edge.
    f0 = fe_cnt; o0 = ov_cnt;
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1);
    check("t1_valid_at_40", {31'd0, valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_at_41", {31'd0, valid}, 32'd1);
    check("t1_data", {24'd0, data}, 32'h0000_00A5);
    man_rd = 1'b1;
    @(negedge clk);
    man_rd = 1'b0;
    check("t1_rd_clears", {31'd0, valid}, 32'd0);
    check("t1_no_fe", fe_cnt - f0, 32'd0);
    check("t1_no_ov", ov_cnt - o0, 32'd0);
    repeat (6) @(negedge clk);

    // One-cycle start glitch.
    f0 = fe_cnt;
    line = 1'b0;
    @(negedge clk);
    line = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_busy_in_start", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    check("t2_busy_back_idle", {31'd0, busy}, 32'd0);
    check("t2_valid", {31'd0, valid}, 32'd0);
    check("t2_no_fe", fe_cnt - f0, 32'd0);
    repeat (6) @(negedge clk);

    // Stop bit low, line held low 20 more cycles.
    f0 = fe_cnt;
    send(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("t3_busy_break", {31'd0, busy}, 32'd1);
    line = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_busy_hold", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t3_busy_release", {31'd0, busy}, 32'd0);
    check("t3_fe_single_pulse", fe_cnt - f0, 32'd1);
    check("t3_valid", {31'd0, valid}, 32'd0);
    repeat (4) @(negedge clk);
    sb.push_back(8'h11);
    send(8'h11, 1'b1);
    recv_read("t3_next_frame");
    repeat (6) @(negedge clk);

    // Back-to-back frames without reading: second one overruns.
    o0 = ov_cnt;
    sb.push_back(8'h01);
    send(8'h01, 1'b1);
    send(8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_ov_single_pulse", ov_cnt - o0, 32'd1);
    check("t4_data_kept", {24'd0, data}, 32'h0000_0001);
    check("t4_valid", {31'd0, valid}, 32'd1);

    // Reset in the middle of DATA of 0x55, held to the end of that frame.
    b55 = 8'h55;
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      line = b55[i];
      repeat (CPB) @(negedge clk);
    end
    line = b55[2];
    repeat (2) @(negedge clk);
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_data", {24'd0, data}, 32'd0);
    check("t5_rst_valid", {31'd0, valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_fe", {31'd0, fe}, 32'd0);
    check("t5_rst_ov", {31'd0, ov}, 32'd0);
    @(negedge clk);
    for (int i = 3; i < WIDTH; i++) begin
      line = b55[i];
      repeat (CPB) @(negedge clk);
    end
    line = 1'b1;
    repeat (CPB) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    check("t5_idle_valid", {31'd0, valid}, 32'd0);
    sb.push_back(8'h66);
    send(8'h66, 1'b1);
    recv_read("t5_next_frame");
    repeat (6) @(negedge clk);

    // Loopback: 256 random words back-to-back, read immediately.
    f0 = fe_cnt; o0 = ov_cnt; r0 = rx_cnt;
    auto_rd = 1'b1;
    for (int n = 0; n < 256; n++) begin
      w = WIDTH'($urandom_range(0, 255));
      sb.push_back(w);
      send(w, 1'b1);
    end
    repeat (10) @(negedge clk);
    auto_rd = 1'b0;
    check("t6_all_received", rx_cnt - r0, 32'd256);
    check("t6_queue_empty", sb.size(), 32'd0);
    check("t6_no_fe", fe_cnt - f0, 32'd0);
    check("t6_no_ov", ov_cnt - o0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
